// File: rtl/vx_commit_arb_pkg.sv
// Shared types for the commit arbiter: packed commit payload and select-width helper.
package vx_commit_arb_pkg;

    typedef struct packed {
        logic [48:0] uuid;
        logic [3:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] data;
        logic        eop;
    } commit_t;

    localparam int COMMIT_W = $bits(commit_t);

    // A single requester still carries a 1-bit select so sel_out always exists.
    function automatic int sel_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_commit_arb_if.sv
// Requester-side and commit-side handshake bundle for vx_commit_arb.
interface vx_commit_arb_if
    import vx_commit_arb_pkg::*;
#(
    parameter int NUM_REQS = 2,
    parameter int DATAW    = COMMIT_W
);
    localparam int SELW = sel_bits(NUM_REQS);

    logic [NUM_REQS-1:0]       valid_in;
    logic [NUM_REQS*DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]       ready_in;
    logic                      valid_out;
    logic [DATAW-1:0]          data_out;
    logic [SELW-1:0]           sel_out;
    logic                      ready_out;

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, sel_out
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, sel_out
    );
endinterface

// File: rtl/vx_commit_arb_buf.sv
// 2-entry elastic FIFO; push_ready comes from registered count only, never from pop_ready.
module vx_commit_arb_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         push_ready,
    output logic         pop_valid,
    output logic [W-1:0] pop_data,
    input  logic         pop_ready
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign push_ready = (count_q != 2'd2);
    assign pop_valid  = (count_q != 2'd0);
    assign pop_data   = mem_q[rd_ptr_q];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_valid && pop_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/vx_commit_arb.sv
// Fixed-priority commit arbiter with starvation promotion and a 2-entry output buffer.
// Optional perf counters are enabled with VX_COMMIT_ARB_PERF_EN.
module vx_commit_arb
    import vx_commit_arb_pkg::*;
#(
    parameter int NUM_REQS   = 2,
    parameter int DATAW      = COMMIT_W,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    vx_commit_arb_if.slave io
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    output logic [NUM_REQS*32-1:0] perf_stall_cycles,
    output logic [31:0]            perf_out_stalls
`endif
);
    localparam int SELW = sel_bits(NUM_REQS);
    localparam int BUFW = SELW + DATAW;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]          starve_q [NUM_REQS];
    logic [3:0]          starve_d [NUM_REQS];
    logic [NUM_REQS-1:0] grant;
    logic [SELW-1:0]     grant_idx;
    logic                any_promo;
    logic                buf_ready;
    logic                push_valid;
    logic [BUFW-1:0]     push_data;
    logic [BUFW-1:0]     pop_data;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        grant_idx = '0;
        any_promo = 1'b0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (io.valid_in[i] && (starve_q[i] == STARVE_LIM)) begin
                any_promo = 1'b1;
                grant_idx = SELW'(i);
            end
        end
        if (!any_promo) begin
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (io.valid_in[i]) grant_idx = SELW'(i);
            end
        end
        grant = (|io.valid_in) ? (NUM_REQS'(1) << grant_idx) : '0;
    end

    assign io.ready_in = (reset || !buf_ready) ? '0 : grant;
    assign push_valid  = |(io.valid_in & io.ready_in);
    assign push_data   = {grant_idx, io.data_in[int'(grant_idx)*DATAW +: DATAW]};

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            starve_d[i] = '0;
            if (io.valid_in[i] && !io.ready_in[i]) begin
                starve_d[i] = (starve_q[i] == STARVE_LIM) ? starve_q[i] : starve_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) starve_q[i] <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    vx_commit_arb_buf #(.W(BUFW)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (buf_ready),
        .pop_valid  (io.valid_out),
        .pop_data   (pop_data),
        .pop_ready  (io.ready_out)
    );

    assign io.sel_out  = pop_data[BUFW-1 -: SELW];
    assign io.data_out = pop_data[DATAW-1:0];

`ifdef VX_COMMIT_ARB_PERF_EN
    logic [31:0] perf_stall_q [NUM_REQS];
    logic [31:0] perf_stall_d [NUM_REQS];
    logic [31:0] perf_out_q, perf_out_d;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            perf_stall_d[i] = perf_stall_q[i] + 32'(io.valid_in[i] && !io.ready_in[i]);
        end
        perf_out_d = perf_out_q + 32'(io.valid_out && !io.ready_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQS; i++) perf_stall_q[i] <= '0;
            perf_out_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_out_q   <= perf_out_d;
        end
    end

    always_comb begin
        perf_stall_cycles = '0;
        for (int i = 0; i < NUM_REQS; i++) perf_stall_cycles[i*32 +: 32] = perf_stall_q[i];
    end
    assign perf_out_stalls = perf_out_q;
`endif
endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb: reset, pass-through, starvation, backpressure, reset mid-stream.
module tb_vx_commit_arb;
    import vx_commit_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vx_commit_arb_if #(.NUM_REQS(2), .DATAW(128)) bus ();

`ifdef VX_COMMIT_ARB_PERF_EN
    logic [63:0] perf_stall;
    logic [31:0] perf_out;
`endif

    vx_commit_arb #(.NUM_REQS(2), .DATAW(128), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus)
`ifdef VX_COMMIT_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall),
        .perf_out_stalls   (perf_out)
`endif
    );

    function automatic logic [127:0] pay(input int id);
        return {32'hC0DE0000, 64'h0, id[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [127:0] d0, input logic [127:0] d1);
        bus.valid_in = v;
        bus.data_in  = {d1, d0};
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Expected output after checking ready: id < 0 means buffer empty.
    task automatic chk_out(input string tag, input int id, input logic sel);
        if (id < 0) begin
            chk({tag, "_vout"}, 128'(bus.valid_out), 128'(0));
        end else begin
            chk({tag, "_vout"}, 128'(bus.valid_out), 128'(1));
            chk({tag, "_data"}, bus.data_out, pay(id));
            chk({tag, "_sel"}, 128'(bus.sel_out), 128'(sel));
        end
    endtask

    logic [1:0] s3_rdy [9] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    int         s3_out [9] = '{-1, 'h30, 'h30, 'h30, 'h30, 'h31, 'h40, 'h32, -1};

    initial begin
        // reset with requesters already asserting
        reset = 1'b1;
        bus.ready_out = 1'b1;
        drive(2'b11, pay(1), pay(2));
        @(negedge clk);
        chk("rst_ready_in", 128'(bus.ready_in), 128'(0));
        next();
        @(negedge clk);
        chk("rst_ready_in2", 128'(bus.ready_in), 128'(0));
        chk("rst_valid_out", 128'(bus.valid_out), 128'(0));
        next();
        reset = 1'b0;
        drive(2'b00, '0, '0);
        @(negedge clk);
        chk("idle_valid_out", 128'(bus.valid_out), 128'(0));

        // single requester 1: A,B,C back to back
        for (int c = 0; c < 5; c++) begin
            next();
            if (c < 3) drive(2'b10, '0, pay('hA0 + c));
            else       drive(2'b00, '0, '0);
            @(negedge clk);
            chk($sformatf("s1_c%0d_ready", c), 128'(bus.ready_in), 128'((c < 3) ? 2'b10 : 2'b00));
            chk_out($sformatf("s1_c%0d", c), (c >= 1 && c <= 3) ? 'hA0 + c - 1 : -1, 1'b1);
        end

        // starvation: req1 promoted at cycle 4
        for (int c = 0; c < 7; c++) begin
            int p;
            int exp_id;
            logic [1:0] exp_rdy;
            next();
            drive({(c <= 4), (c <= 5)}, pay('h10 + ((c < 4) ? c : 4)), pay('hE0));
            @(negedge clk);
            exp_rdy = (c < 4) ? 2'b01 : (c == 4) ? 2'b10 : (c == 5) ? 2'b01 : 2'b00;
            chk($sformatf("s2_c%0d_ready", c), 128'(bus.ready_in), 128'(exp_rdy));
            p = c - 1;
            exp_id = (c == 0) ? -1 : (p < 4) ? 'h10 + p : (p == 4) ? 'hE0 : 'h14;
            chk_out($sformatf("s2_c%0d", c), exp_id, (p == 4));
        end
`ifdef VX_COMMIT_ARB_PERF_EN
        chk("perf_stall_r1", 128'(perf_stall[63:32]), 128'(4));
        chk("perf_stall_r0", 128'(perf_stall[31:0]), 128'(1));
        chk("perf_out_stalls", 128'(perf_out), 128'(0));
`endif

        // backpressure, full-with-pop refusal, promotion into first free slot
        for (int d = 0; d < 9; d++) begin
            next();
            bus.ready_out = (d >= 4);
            drive({(d <= 5), (d <= 6)}, pay('h30 + ((d < 2) ? d : 2)), pay('h40));
            @(negedge clk);
            chk($sformatf("s3_d%0d_ready", d), 128'(bus.ready_in), 128'(s3_rdy[d]));
            chk_out($sformatf("s3_d%0d", d), s3_out[d], (s3_out[d] == 'h40));
        end

        // reset while full
        next();
        bus.ready_out = 1'b0;
        drive(2'b01, pay('h50), '0);
        @(negedge clk);
        chk("s5_e0_ready", 128'(bus.ready_in), 128'(2'b01));
        next();
        drive(2'b01, pay('h51), '0);
        @(negedge clk);
        chk("s5_e1_ready", 128'(bus.ready_in), 128'(2'b01));
        chk_out("s5_e1", 'h50, 1'b0);
        next();
        reset = 1'b1;
        drive(2'b01, pay('h52), '0);
        @(negedge clk);
        chk("s5_e2_ready", 128'(bus.ready_in), 128'(2'b00));
        chk_out("s5_e2", 'h50, 1'b0);
        next();
        reset = 1'b0;
        bus.ready_out = 1'b1;
        @(negedge clk);
        chk("s5_e3_ready", 128'(bus.ready_in), 128'(2'b01));
        chk_out("s5_e3", -1, 1'b0);
        next();
        drive(2'b00, '0, '0);
        @(negedge clk);
        chk_out("s5_e4", 'h52, 1'b0);
        next();
        @(negedge clk);
        chk_out("s5_e5", -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
